// File: rtl/gray_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_pkg
// Description : Shared types, defaults and helper functions for the
//               arbitrated binary-to-Gray converter.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_conv_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_ID_W  = $clog2(DEF_NREQ);

    // Helpers work on the widest supported vectors; callers zero-extend and
    // truncate, which leaves the Gray result of the narrower word unchanged.
    localparam int MAX_W    = 64;
    localparam int MAX_NREQ = 32;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Round-robin search: first set bit of valid starting at ptr, wrapping at nreq.
    function automatic logic rr_pick(
        input  logic [MAX_NREQ-1:0] valid,
        input  int                  ptr,
        input  int                  nreq,
        output int                  idx
    );
        logic found;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (!found && (k < nreq) && valid[(ptr + k) % nreq]) begin
                found = 1'b1;
                idx   = (ptr + k) % nreq;
            end
        end
        return found;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_arbiter_if
// Description : Requester-side and result-side handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_conv_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

endinterface
`default_nettype wire

// File: rtl/gray_encode_core.sv
`default_nettype none
// ============================================================================
// Module      : gray_encode_core
// Description : Combinational binary-to-Gray encoder (shared datapath).
// Revision    : 1.0 - initial release
// ============================================================================
module gray_encode_core
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire  [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = WIDTH'(bin2gray(MAX_W'(i_bin)));

endmodule
`default_nettype wire

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_arbiter
// Description : Round-robin arbitration of NREQ requesters onto one Gray
//               encoder, with a registered, tagged result stage and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int CNT_W = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    gray_conv_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]    conv_count
);

    localparam int ID_W = $clog2(NREQ);

    out_state_e        state_q, state_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              w_free;
    logic              w_found;
    logic              w_gnt;
    logic              w_accept;
    int                w_pick_idx;
    logic [ID_W-1:0]   w_gnt_id;
    logic [NREQ-1:0]   w_ready;
    logic [WIDTH-1:0]  w_gnt_bin;
    logic [WIDTH-1:0]  w_gnt_gray;

    // Grant is combinational so a draining result can be refilled in the
    // same cycle; it is also suppressed while reset is held.
    always_comb begin
        w_pick_idx = 0;
        w_free     = (state_q == ST_EMPTY) || bus.out_ready;
        w_found    = rr_pick(MAX_NREQ'(bus.req_valid), int'(rr_ptr_q), NREQ, w_pick_idx);
        w_gnt      = w_free && w_found && !rst;
        w_gnt_id   = ID_W'(w_pick_idx);
        w_ready    = '0;
        if (w_gnt) begin
            w_ready[w_gnt_id] = 1'b1;
        end
        w_gnt_bin  = bus.req_data[int'(w_gnt_id)*WIDTH +: WIDTH];
    end

    gray_encode_core #(
        .WIDTH (WIDTH)
    ) u_encode (
        .i_bin  (w_gnt_bin),
        .o_gray (w_gnt_gray)
    );

    always_comb begin
        w_accept   = (state_q == ST_FULL) && bus.out_ready;
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q + CNT_W'(w_accept);
        if (w_gnt) begin
            state_d    = ST_FULL;
            out_data_d = w_gnt_gray;
            out_id_d   = w_gnt_id;
            rr_ptr_d   = ID_W'((w_pick_idx + 1) % NREQ);
        end else if (w_accept) begin
            state_d    = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_id_q   <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign conv_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_conv_arbiter
// Description : Scoreboard bench for gray_conv_arbiter with a queue-based
//               round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_conv_arbiter;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] conv_count;

    gray_conv_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    gray_conv_arbiter #(
        .WIDTH (W),
        .NREQ  (N),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           id;
    } res_t;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] rq [N][$];
    res_t         sb[$];
    res_t         acc[$];
    int           mptr  = 0;
    int           mcnt  = 0;
    bit           mfull = 1'b0;

    function automatic logic [W-1:0] gray_ref(input logic [W-1:0] b);
        return b ^ {1'b0, b[W-1:1]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Requester drivers: present the head of each queue, valid independent of ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i]       = (rq[i].size() > 0);
                bus.req_data[i*W +: W] = (rq[i].size() > 0) ? rq[i][0] : '0;
            end
        end
    end

    // Monitor and reference model, evaluated mid-cycle.
    initial begin
        int           g;
        int           j;
        logic [N-1:0] er;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("out_valid", int'(bus.out_valid), int'(mfull));
                chk("conv_count", int'(conv_count), mcnt);
                if (mfull) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard: got out_valid=1 expected no pending result");
                    end else begin
                        chk("out_data", int'(bus.out_data), int'(sb[0].data));
                        chk("out_id", int'(bus.out_id), sb[0].id);
                    end
                end
                g = -1;
                if (!mfull || bus.out_ready) begin
                    for (int k = 0; k < N; k++) begin
                        j = (mptr + k) % N;
                        if (g < 0 && bus.req_valid[j]) g = j;
                    end
                end
                er = (g >= 0) ? (N'(1) << g) : '0;
                chk("req_ready", int'(bus.req_ready), int'(er));
                if (mfull && bus.out_ready) begin
                    acc.push_back('{bus.out_data, int'(bus.out_id)});
                    if (sb.size() > 0) void'(sb.pop_front());
                    mcnt = (mcnt + 1) % (1 << CW);
                end
                if (g >= 0 && rq[g].size() > 0) begin
                    sb.push_back('{gray_ref(rq[g][0]), g});
                    void'(rq[g].pop_front());
                    mptr = (g + 1) % N;
                end
                mfull = (g >= 0) || (mfull && !bus.out_ready);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (bus.out_valid) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL %s: got no out_valid expected out_valid within %0d cycles", name, budget);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bus.out_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (all_empty() && sb.size() == 0 && !bus.out_valid) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL %s: got traffic pending expected drained within %0d cycles", name, budget);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset(input bit check);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        if (check) begin
            chk("async rst out_valid", int'(bus.out_valid), 0);
            chk("async rst conv_count", int'(conv_count), 0);
            chk("async rst req_ready", int'(bus.req_ready), 0);
        end
        for (int i = 0; i < N; i++) rq[i].delete();
        sb.delete();
        acc.delete();
        mptr  = 0;
        mfull = 1'b0;
        mcnt  = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rr_exp [N];
        int           n;
        rr_exp = '{4'b0010, 4'b1110, 4'b1000, 4'b0000};
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset conv_count", int'(conv_count), 0);
        chk("reset req_ready", int'(bus.req_ready), 0);
        rst = 1'b0;

        // Single conversion
        bus.out_ready = 1'b1;
        rq[0].push_back(4'b0011);
        wait_valid("basic", 20);
        chk("basic out_data", int'(bus.out_data), 4'b0010);
        chk("basic out_id", int'(bus.out_id), 0);
        wait_drain("basic", 50);

        // Round robin from a fresh pointer
        do_reset(1'b0);
        bus.out_ready = 1'b1;
        rq[0].push_back(4'b0011);
        rq[1].push_back(4'b1011);
        rq[2].push_back(4'b1111);
        rq[3].push_back(4'b0000);
        wait_drain("rr", 50);
        chk("rr accepts", acc.size(), 4);
        if (acc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr id", acc[i].id, i);
                chk("rr data", int'(acc[i].data), int'(rr_exp[i]));
            end
        end
        chk("rr conv_count", int'(conv_count), 4);

        // Backpressure, then drain with same-cycle refill
        bus.out_ready = 1'b0;
        rq[1].push_back(4'b0110);
        rq[2].push_back(4'b1001);
        wait_valid("bp", 20);
        repeat (3) begin
            chk("bp hold data", int'(bus.out_data), 4'b0101);
            chk("bp hold id", int'(bus.out_id), 1);
            chk("bp hold req_ready", int'(bus.req_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp refill req_ready", int'(bus.req_ready), 4'b0100);
        tick();
        chk("bp refill out_valid", int'(bus.out_valid), 1);
        chk("bp refill data", int'(bus.out_data), 4'b1101);
        chk("bp refill id", int'(bus.out_id), 2);
        wait_drain("bp", 50);

        // Move pointer to 2, then only requesters 0 and 3 compete
        rq[1].push_back(4'b0001);
        wait_drain("fair setup", 50);
        acc.delete();
        rq[0].push_back(4'b0100);
        rq[0].push_back(4'b0101);
        rq[3].push_back(4'b1100);
        rq[3].push_back(4'b1101);
        wait_drain("fair", 50);
        chk("fair accepts", acc.size(), 4);
        if (acc.size() >= 4) begin
            chk("fair id0", acc[0].id, 3);
            chk("fair id1", acc[1].id, 0);
            chk("fair id2", acc[2].id, 3);
            chk("fair id3", acc[3].id, 0);
            chk("fair data0", int'(acc[0].data), 4'b1010);
            chk("fair data1", int'(acc[1].data), 4'b0110);
        end

        // Reset while a result is pending
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) rq[i].push_back(4'(i + 5));
        wait_valid("mid rst", 20);
        do_reset(1'b1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) rq[i].push_back(4'(i + 8));
        wait_drain("post rst", 50);
        chk("post rst accepts", acc.size(), 4);
        if (acc.size() > 0) chk("post rst first id", acc[0].id, 0);

        // Counter wrap with random traffic and stalls
        do_reset(1'b0);
        n = 0;
        while (n < 17) begin
            if ($urandom_range(1, 0) == 1) begin
                rq[$urandom_range(N-1, 0)].push_back(W'($urandom));
                n++;
            end
            bus.out_ready = ($urandom_range(3, 0) != 0);
            tick();
        end
        wait_drain("wrap", 300);
        chk("wrap accepts", acc.size(), 17);
        chk("wrap conv_count", int'(conv_count), 1);

        // Longer random run, possibly several requests per cycle
        n = 0;
        while (n < 150) begin
            for (int i = 0; i < N; i++) begin
                if (n < 150 && $urandom_range(2, 0) == 0) begin
                    rq[i].push_back(W'($urandom));
                    n++;
                end
            end
            bus.out_ready = ($urandom_range(3, 0) != 0);
            tick();
        end
        wait_drain("random", 1000);
        chk("random accepts", acc.size(), 167);
        chk("random conv_count", int'(conv_count), 167 % 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
